// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, reset values,
// FSM encoding and immediate extraction helpers.
package if_stage_pkg;

    localparam logic [6:0]  OP_JAL       = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;
    localparam logic [1:0]  BHT_INIT     = 2'b01;

    typedef enum logic {RUN, WAIT_MEM} fetch_state_e;

    function automatic logic [31:0] imm_j(input logic [31:7] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:7] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Word-fetch bus between the fetch stage (master) and the memory controller (slave).
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        done;

    modport master (output req, addr, input inst, done);
    modport slave  (input req, addr, output inst, done);
endinterface

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line I-cache: combinational lookup, synchronous fill.
module if_stage_icache #(
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_word_addr,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [29:0] wr_word_addr,
    input  logic [31:0] wr_data
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags      [LINES];
    logic [31:0]      line_data [LINES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx  = rd_word_addr[IDX_W-1:0];
    assign wr_idx  = wr_word_addr[IDX_W-1:0];
    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_word_addr[29:IDX_W]);
    assign rd_data = line_data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]      <= wr_word_addr[29:IDX_W];
            line_data[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, I-cache front end with miss fill, static JAL and
// 2-bit BHT branch prediction, EX redirect.
//   state    | meaning
//   RUN      | look up pc each cycle; hit emits, miss starts a fill
//   WAIT_MEM | fill outstanding; no emit until line written
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          ICACHE_IDX_W = 8,
    parameter int          BHT_IDX_W    = 8,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              br_flag_i,
    input  logic [31:0]       br_target_i,
    input  logic              bp_upd_i,
    input  logic [31:0]       bp_upd_pc_i,
    input  logic              bp_upd_taken_i,
    if_stage_if.master        mem,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              jmp_o,
    output logic              valid_o,
    output logic              stall_if_o
);
    localparam int BHT_SIZE = 1 << BHT_IDX_W;

    fetch_state_e state, state_next;
    logic [31:0]  pc;
    logic [1:0]   bht [BHT_SIZE];
    logic         hit;
    logic [31:0]  word;
    logic [31:0]  pc_next;
    logic         jmp_next;
    logic         do_emit, do_miss, do_fill;
    logic [BHT_IDX_W-1:0] rd_bht_idx, upd_bht_idx;
    logic         unused_bits;

    assign unused_bits = ^{bp_upd_pc_i[31:BHT_IDX_W+2], bp_upd_pc_i[1:0], mem.addr[1:0]};
    assign rd_bht_idx  = pc[BHT_IDX_W+1:2];
    assign upd_bht_idx = bp_upd_pc_i[BHT_IDX_W+1:2];
    assign stall_if_o  = (state == WAIT_MEM);

    if_stage_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
        .clk          (clk),
        .rst          (rst),
        .rd_word_addr (pc[31:2]),
        .hit          (hit),
        .rd_data      (word),
        .wr_en        (do_fill),
        .wr_word_addr (mem.addr[31:2]),
        .wr_data      (mem.inst)
    );

    // Prediction reads the BHT before this edge's update lands.
    always_comb begin
        pc_next  = pc + 32'd4;
        jmp_next = 1'b0;
        if (word[6:0] == OP_JAL) begin
            pc_next  = pc + imm_j(word[31:7]);
            jmp_next = 1'b1;
        end else if (word[6:0] == OP_BRANCH && bht[rd_bht_idx][1]) begin
            pc_next  = pc + imm_b(word[31:7]);
            jmp_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        do_emit    = 1'b0;
        do_miss    = 1'b0;
        do_fill    = 1'b0;
        if (rdy && !rst) begin
            case (state)
                RUN: begin
                    if (!br_flag_i && !stall_i) begin
                        if (hit) begin
                            do_emit = 1'b1;
                        end else begin
                            do_miss    = 1'b1;
                            state_next = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem.done) begin
                        do_fill    = 1'b1;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            pc_o     <= '0;
            inst_o   <= '0;
            jmp_o    <= 1'b0;
            valid_o  <= 1'b0;
            mem.req  <= 1'b0;
            mem.addr <= '0;
        end else if (rdy) begin
            if (br_flag_i)
                pc <= br_target_i;
            else if (do_emit)
                pc <= pc_next;

            if (do_emit) begin
                pc_o    <= pc;
                inst_o  <= word;
                jmp_o   <= jmp_next;
                valid_o <= 1'b1;
            end else if (do_miss || (state == RUN && br_flag_i)) begin
                valid_o <= 1'b0;
            end

            if (do_miss) begin
                mem.req  <= 1'b1;
                mem.addr <= pc;
            end else if (do_fill) begin
                mem.req  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++)
                bht[i] <= BHT_INIT;
        end else if (rdy && bp_upd_i) begin
            if (bp_upd_taken_i && bht[upd_bht_idx] != 2'b11)
                bht[upd_bht_idx] <= bht[upd_bht_idx] + 2'd1;
            else if (!bp_upd_taken_i && bht[upd_bht_idx] != 2'b00)
                bht[upd_bht_idx] <= bht[upd_bht_idx] - 2'd1;
        end
    end
endmodule
